// File: rtl/bvh_leaf_writer_pkg.sv
// bvh_leaf_writer_pkg: shared record layout, sizes and FSM states for the leaf loader (RB set by BVH_LEAF_WRITER_AABB_EN)
package bvh_leaf_writer_pkg;
  localparam int BVH_LEAF_RECORD_WIDTH = 232;
  localparam int HDR_WIDTH = 16;
  localparam int MINX_LSB = 200;
  localparam int MINY_LSB = 168;
  localparam int MINZ_LSB = 136;
  localparam int MAXX_LSB = 104;
  localparam int MAXY_LSB = 72;
  localparam int MAXZ_LSB = 40;
  localparam int SPRIM_LSB = 8;
  localparam int NPRIM_LSB = 0;
`ifdef BVH_LEAF_WRITER_AABB_EN
  localparam int RB = 29;
`else
  localparam int RB = 5;
`endif
  localparam int ASM_W = RB * 8;
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERR} lw_state_e;
endpackage

// File: rtl/bvh_leaf_record_packer.sv
// bvh_leaf_record_packer: shifts MSB-first bytes into a record and flags the byte that completes it
module bvh_leaf_record_packer
  import bvh_leaf_writer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             accept,
  input  logic [7:0]       in_data,
  output logic             rec_valid,
  output logic [ASM_W-1:0] rec_data
);
  logic [ASM_W-1:0] asm_q;
  logic [15:0] bcnt;
  // rec_data is the record including the byte being accepted, so it is complete when rec_valid fires
  assign rec_data = {asm_q[ASM_W-9:0], in_data};
  assign rec_valid = accept && bcnt == 16'(RB - 1);
  // shift accepted bytes and wrap the byte counter at the record boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q <= '0;
      bcnt <= '0;
    end else if (clear) begin
      bcnt <= '0;
    end else if (accept) begin
      asm_q <= rec_data;
      bcnt <= rec_valid ? 16'd0 : bcnt + 16'd1;
    end
  end
endmodule

// File: rtl/bvh_leaf_writer.sv
// bvh_leaf_writer: loads leaf records from a host byte stream into leaf RAM (macro BVH_LEAF_WRITER_AABB_EN selects full AABB records)
module bvh_leaf_writer
  import bvh_leaf_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH = 1024,
  parameter int MAX_PRIMS = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             in_valid,
  input  logic [7:0]                       in_data,
  output logic                             in_ready,
  output logic                             wr_en,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [BVH_LEAF_RECORD_WIDTH-1:0] wr_data,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [HDR_WIDTH-1:0]             leaf_count
);
  localparam logic [HDR_WIDTH:0] DEP = (HDR_WIDTH + 1)'(DEPTH);
  localparam logic [7:0] MP = 8'(MAX_PRIMS);
  lw_state_e state_q, state_d;
  logic [7:0] hdr_lo;
  logic [HDR_WIDTH-1:0] rec_cnt, cnt;
  logic arm, acc, rec_valid, bad;
  logic [ASM_W-1:0] rec_data;
  assign busy = state_q == S_HDR0 || state_q == S_HDR1 || state_q == S_DATA;
  assign in_ready = busy;
  assign done = state_q == S_DONE;
  assign error = state_q == S_ERR;
  assign arm = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign acc = in_valid && in_ready;
  assign cnt = {in_data, hdr_lo};
  assign bad = in_data == 8'd0 || in_data > MP;
  bvh_leaf_record_packer u_packer (
    .clk(clk),
    .reset(reset),
    .clear(arm),
    .accept(acc && state_q == S_DATA),
    .in_data(in_data),
    .rec_valid(rec_valid),
    .rec_data(rec_data)
  );
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // next state: header decode, primitive check and completion on the last scheduled write
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_HDR0;
      S_HDR0: if (in_valid) state_d = S_HDR1;
      S_HDR1: if (in_valid) state_d = cnt == '0 ? S_DONE : {1'b0, cnt} > DEP ? S_ERR : S_DATA;
      S_DATA: if (rec_valid) state_d = bad ? S_ERR : rec_cnt + 16'd1 == leaf_count ? S_DONE : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end
  // header latch, record counter and the registered RAM write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_lo <= '0;
      leaf_count <= '0;
      rec_cnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (arm) rec_cnt <= '0;
      if (state_q == S_HDR0 && in_valid) hdr_lo <= in_data;
      if (state_q == S_HDR1 && in_valid) leaf_count <= cnt;
      if (rec_valid && !bad) begin
        wr_en <= 1'b1;
        wr_data <= BVH_LEAF_RECORD_WIDTH'(rec_data);
        wr_addr <= rec_cnt[ADDR_WIDTH-1:0];
        rec_cnt <= rec_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_bvh_leaf_writer.sv
// tb_bvh_leaf_writer: randomized directed checks of the leaf loader against a record-list reference model
module tb_bvh_leaf_writer;
  import bvh_leaf_writer_pkg::*;
  localparam int AW = 10;
  localparam int DEPTH = 1024;
  localparam int MAXP = 8;
  logic clk = 1'b0;
  logic reset, start, in_valid, in_ready, wr_en, busy, done, error;
  logic [7:0] in_data;
  logic [AW-1:0] wr_addr;
  logic [231:0] wr_data;
  logic [15:0] leaf_count;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [231:0] recs[$];
  logic [231:0] exp_data[$];
  logic [231:0] obs_data[$];
  int exp_addr[$];
  int obs_addr[$];
  int obs_cyc[$];

  bvh_leaf_writer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .MAX_PRIMS(MAXP)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .leaf_count(leaf_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_en) begin
    obs_addr.push_back(int'(wr_addr));
    obs_data.push_back(wr_data);
    obs_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [231:0] obs, input logic [231:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [231:0] mk_rec(input logic [7:0] np);
    logic [231:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[199:0], 32'($urandom)};
    r[39:8] = 32'($urandom);
    r[7:0] = np;
    return r;
  endfunction

  function automatic logic [231:0] visible(input logic [231:0] r);
    return (r << (232 - ASM_W)) >> (232 - ASM_W);
  endfunction

  task automatic gen(input int n, input int bad);
    recs.delete();
    for (int i = 0; i < n; i++) recs.push_back(mk_rec(i == bad ? 8'd9 : 8'($urandom_range(1, MAXP))));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bit acc = 1'b0;
    while (!acc && n < 400) begin
      @(negedge clk);
      in_data = b;
      in_valid = $urandom_range(99) >= gap;
      acc = in_valid && in_ready;
      n++;
    end
    if (!acc) chk("byte_accept", 232'd0, 232'd1);
  endtask

  task automatic send_rec(input logic [231:0] r, input int nbytes, input int gap);
    for (int i = 0; i < nbytes; i++) send_byte(r[(RB-1-i)*8 +: 8], gap);
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    obs_data.delete(); obs_addr.delete(); obs_cyc.delete();
    exp_data.delete(); exp_addr.delete();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input int n, input int gap, input int bad);
    do_start();
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int i = 0; i < n; i++) begin
      if (bad < 0 || i < bad) begin
        exp_data.push_back(visible(recs[i]));
        exp_addr.push_back(i);
      end
      send_rec(recs[i], RB, gap);
      if (i == bad) break;
    end
    go_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic verify(input string tag);
    chk({tag, "_nwrites"}, 232'(obs_data.size()), 232'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      chk({tag, "_addr"}, 232'(obs_addr[i]), 232'(exp_addr[i]));
      chk({tag, "_data"}, obs_data[i], exp_data[i]);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, 232'(wr_en), 232'd0);
    chk({tag, "_wr_data"}, wr_data, 232'd0);
    chk({tag, "_wr_addr"}, 232'(wr_addr), 232'd0);
    chk({tag, "_leaf_count"}, 232'(leaf_count), 232'd0);
    chk({tag, "_flags"}, 232'({busy, done, error, in_ready}), 232'd0);
  endtask

  initial begin
    logic [231:0] r;
    int n;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    gen(2, -1);
    r = recs[0]; r[39:0] = {32'h10, 8'h03}; recs[0] = r;
    r = recs[1]; r[39:0] = {32'h13, 8'h01}; recs[1] = r;
    run_load(2, 0, -1);
    verify("two_rec");
    chk("two_rec_field0", 232'(obs_data.size() > 0 ? obs_data[0][39:0] : 40'd0), 232'({32'h10, 8'h03}));
    chk("two_rec_field1", 232'(obs_data.size() > 1 ? obs_data[1][39:0] : 40'd0), 232'({32'h13, 8'h01}));
    chk("two_rec_spacing", 232'(obs_cyc.size() > 1 ? obs_cyc[1] - obs_cyc[0] : 0), 232'(RB));
    chk("two_rec_done", 232'({done, error, busy, in_ready}), 232'b1000);
    chk("two_rec_count", 232'(leaf_count), 232'd2);

    do_start();
    chk("zero_busy", 232'(busy), 232'd1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    go_idle();
    chk("zero_done", 232'({done, in_ready}), 232'b10);
    repeat (3) @(negedge clk);
    chk("zero_nwrites", 232'(obs_data.size()), 232'd0);

    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    go_idle();
    repeat (2) @(negedge clk);
    chk("depth_err", 232'({error, done, in_ready}), 232'b100);
    chk("depth_count", 232'(leaf_count), 232'(DEPTH + 1));
    chk("depth_nwrites", 232'(obs_data.size()), 232'd0);
    do_start();
    chk("rearm", 232'({error, busy}), 232'b01);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    go_idle();
    chk("rearm_done", 232'(done), 232'd1);

    gen(3, 1);
    run_load(3, 0, 1);
    verify("bad_prims");
    chk("bad_prims_err", 232'({error, done, in_ready}), 232'b100);

    gen(3, -1);
    run_load(3, 0, -1);
    verify("gapless");
    chk("gapless_sp1", 232'(obs_cyc.size() > 2 ? obs_cyc[1] - obs_cyc[0] : 0), 232'(RB));
    chk("gapless_sp2", 232'(obs_cyc.size() > 2 ? obs_cyc[2] - obs_cyc[1] : 0), 232'(RB));
    run_load(3, 50, -1);
    verify("gappy");
    chk("gappy_done", 232'(done), 232'd1);

    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 4);
      gen(n, -1);
      run_load(n, $urandom_range(0, 60), -1);
      verify("rand");
      chk("rand_count", 232'(leaf_count), 232'(n));
    end

    gen(2, -1);
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_rec(recs[0], RB, 0);
    send_rec(recs[1], RB > 15 ? 15 : RB - 2, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    gen(1, -1);
    run_load(1, 0, -1);
    verify("restart");
    chk("restart_done", 232'({done, error}), 232'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
